riscv_mem_arbiter: RTL and testbench



---
 rtl/riscv_mem_arbiter.sv | 72 +++++++
 tb/tb_riscv_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin share of one memory port between dcache and icache block transfers.
module riscv_mem_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 23
) (
  input  logic                  i_riscv_arb_clk,
  input  logic                  i_riscv_arb_rst_n,
  input  logic                  i_riscv_arb_dc_rden,
  input  logic                  i_riscv_arb_dc_wren,
  input  logic [S_ADDR-1:0]     i_riscv_arb_dc_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_dc_wdata,
  output logic                  o_riscv_arb_dc_ready,
  input  logic                  i_riscv_arb_ic_rden,
  input  logic [S_ADDR-1:0]     i_riscv_arb_ic_addr,
  output logic                  o_riscv_arb_ic_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_rdata,
  output logic                  o_riscv_arb_mem_rden,
  output logic                  o_riscv_arb_mem_wren,
  output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata,
  input  logic                  i_riscv_arb_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DC_XFER = 2'd1;
  localparam logic [1:0] IC_XFER = 2'd2;
  logic [1:0]            state;
  logic                  last_ic;
  logic                  cmd_rd;
  logic                  cmd_wr;
  logic [S_ADDR-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  dc_req;
  logic                  grant_ic;
  logic                  grant_dc;
  assign dc_req   = i_riscv_arb_dc_rden | i_riscv_arb_dc_wren;
  // last_ic=0 means the dcache went last, so the icache takes a tie
  assign grant_ic = (state == IDLE) & i_riscv_arb_ic_rden & (~dc_req | ~last_ic);
  assign grant_dc = (state == IDLE) & dc_req & ~grant_ic;
  always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
    if (!i_riscv_arb_rst_n) begin
      state     <= IDLE;
      last_ic   <= 1'b0;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (state == IDLE) begin
      if (grant_ic | grant_dc) begin
        state     <= grant_ic ? IC_XFER : DC_XFER;
        last_ic   <= grant_ic;
        cmd_rd    <= grant_ic | (i_riscv_arb_dc_rden & ~i_riscv_arb_dc_wren);
        cmd_wr    <= grant_dc & i_riscv_arb_dc_wren;
        cmd_addr  <= grant_ic ? i_riscv_arb_ic_addr : i_riscv_arb_dc_addr;
        cmd_wdata <= grant_ic ? '0 : i_riscv_arb_dc_wdata;
      end
    end else if (i_riscv_arb_mem_ready) begin
      state     <= IDLE;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end
  end
  assign o_riscv_arb_mem_rden  = cmd_rd;
  assign o_riscv_arb_mem_wren  = cmd_wr;
  assign o_riscv_arb_mem_addr  = cmd_addr;
  assign o_riscv_arb_mem_wdata = cmd_wdata;
  assign o_riscv_arb_dc_ready  = (state == DC_XFER) & i_riscv_arb_mem_ready;
  assign o_riscv_arb_ic_ready  = (state == IC_XFER) & i_riscv_arb_mem_ready;
  assign o_riscv_arb_rdata     = i_riscv_arb_mem_rdata;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed self-checking bench for the dcache/icache memory arbiter.
module tb_riscv_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dc_rden = 1'b0;
  logic         dc_wren = 1'b0;
  logic [22:0]  dc_addr = '0;
  logic [127:0] dc_wdata = '0;
  logic         dc_ready;
  logic         ic_rden = 1'b0;
  logic [22:0]  ic_addr = '0;
  logic         ic_ready;
  logic [127:0] rdata;
  logic         mem_rden;
  logic         mem_wren;
  logic [22:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;
  int checks = 0;
  int failures = 0;
  localparam logic [127:0] RD_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] WB_DATA = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  always #5 clk = ~clk;
  riscv_mem_arbiter #(.DATA_WIDTH(128), .S_ADDR(23)) dut (
    .i_riscv_arb_clk(clk),
    .i_riscv_arb_rst_n(rst_n),
    .i_riscv_arb_dc_rden(dc_rden),
    .i_riscv_arb_dc_wren(dc_wren),
    .i_riscv_arb_dc_addr(dc_addr),
    .i_riscv_arb_dc_wdata(dc_wdata),
    .o_riscv_arb_dc_ready(dc_ready),
    .i_riscv_arb_ic_rden(ic_rden),
    .i_riscv_arb_ic_addr(ic_addr),
    .o_riscv_arb_ic_ready(ic_ready),
    .o_riscv_arb_rdata(rdata),
    .o_riscv_arb_mem_rden(mem_rden),
    .o_riscv_arb_mem_wren(mem_wren),
    .o_riscv_arb_mem_addr(mem_addr),
    .o_riscv_arb_mem_wdata(mem_wdata),
    .i_riscv_arb_mem_ready(mem_ready),
    .i_riscv_arb_mem_rdata(mem_rdata)
  );
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_rden"}, 128'(mem_rden), 128'(0));
    check({tag, "_wren"}, 128'(mem_wren), 128'(0));
    check({tag, "_dcrdy"}, 128'(dc_ready), 128'(0));
    check({tag, "_icrdy"}, 128'(ic_ready), 128'(0));
  endtask
  initial begin
    #12;
    check_idle("rst");
    check("rst_addr", 128'(mem_addr), 128'(0));
    check("rst_wdata", mem_wdata, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    // dcache read, memory answers on the fourth transfer cycle
    @(negedge clk);
    dc_rden = 1'b1;
    dc_addr = 23'h1A2B3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_rden", 128'(mem_rden), 128'(1));
      check("rd_addr", 128'(mem_addr), 128'(23'h1A2B3C));
      check("rd_wait_dcrdy", 128'(dc_ready), 128'(0));
    end
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = RD_BEEF;
    #1;
    check("rd_dcrdy", 128'(dc_ready), 128'(1));
    check("rd_icrdy", 128'(ic_ready), 128'(0));
    check("rd_rdata", rdata, RD_BEEF);
    @(negedge clk);
    mem_ready = 1'b0;
    dc_rden = 1'b0;
    #1;
    check_idle("rd_done");
    // fresh reset, then both caches request continuously
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    dc_rden = 1'b1;
    dc_addr = 23'h000222;
    dc_wdata = 128'hAAAA;
    ic_rden = 1'b1;
    ic_addr = 23'h000111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_rden", 128'(mem_rden), 128'(1));
      check("rr_addr", 128'(mem_addr), 128'(k % 2 == 0 ? 23'h000111 : 23'h000222));
      check("rr_wdata", mem_wdata, k % 2 == 0 ? 128'(0) : 128'hAAAA);
      mem_ready = 1'b1;
      mem_rdata = 128'(k + 1);
      #1;
      check("rr_icrdy", 128'(ic_ready), 128'(k % 2 == 0));
      check("rr_dcrdy", 128'(dc_ready), 128'(k % 2 == 1));
      check("rr_rdata", rdata, 128'(k + 1));
      @(negedge clk);
      mem_ready = 1'b0;
      if (k == 5) begin
        dc_rden = 1'b0;
        ic_rden = 1'b0;
      end
      #1;
      check_idle("rr_gap");
    end
    // dcache writeback with inputs changed after grant
    dc_wren = 1'b1;
    dc_addr = 23'h000055;
    dc_wdata = WB_DATA;
    @(negedge clk);
    check("wb_wren", 128'(mem_wren), 128'(1));
    check("wb_rden", 128'(mem_rden), 128'(0));
    check("wb_addr", 128'(mem_addr), 128'(23'h000055));
    check("wb_wdata", mem_wdata, WB_DATA);
    dc_addr = 23'h7FFFFF;
    dc_wdata = ~WB_DATA;
    repeat (2) @(negedge clk);
    check("wb_hold_addr", 128'(mem_addr), 128'(23'h000055));
    check("wb_hold_wdata", mem_wdata, WB_DATA);
    check("wb_hold_wren", 128'(mem_wren), 128'(1));
    mem_ready = 1'b1;
    #1;
    check("wb_dcrdy", 128'(dc_ready), 128'(1));
    @(negedge clk);
    mem_ready = 1'b0;
    dc_wren = 1'b0;
    #1;
    check_idle("wb_done");
    // rden and wren together must become a write
    dc_rden = 1'b1;
    dc_wren = 1'b1;
    dc_addr = 23'h000077;
    @(negedge clk);
    check("rw_wren", 128'(mem_wren), 128'(1));
    check("rw_rden", 128'(mem_rden), 128'(0));
    check("rw_wdata", mem_wdata, ~WB_DATA);
    mem_ready = 1'b1;
    #1;
    check("rw_dcrdy", 128'(dc_ready), 128'(1));
    @(negedge clk);
    mem_ready = 1'b0;
    dc_rden = 1'b0;
    dc_wren = 1'b0;
    // spurious completion while idle
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_idle("spur");
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_idle("spur_after");
    check("spur_state", 128'(dut.state), 128'(0));
    // icache request, then reset in the middle of its transfer
    ic_rden = 1'b1;
    ic_addr = 23'h3ABCDE;
    @(negedge clk);
    check("ic_rden", 128'(mem_rden), 128'(1));
    check("ic_addr", 128'(mem_addr), 128'(23'h3ABCDE));
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_idle("abort");
    check("abort_addr", 128'(mem_addr), 128'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rearb_rden", 128'(mem_rden), 128'(1));
    check("rearb_addr", 128'(mem_addr), 128'(23'h3ABCDE));
    mem_ready = 1'b1;
    #1;
    check("rearb_icrdy", 128'(ic_ready), 128'(1));
    check("rearb_dcrdy", 128'(dc_ready), 128'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    ic_rden = 1'b0;
    #1;
    check_idle("end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
